// File: rtl/mmio_bridge_if.sv
// mmio_bridge_if: cpu memory-port bundle (word address, write data, strobes, read data).
interface mmio_bridge_if;
  logic [15:0] address;
  logic [15:0] wdata;
  logic        wren_n;
  logic        oen_n;
  logic [15:0] rdata;

  modport master (output address, output wdata, output wren_n, output oen_n, input rdata);
  modport slave  (input address, input wdata, input wren_n, input oen_n, output rdata);
endinterface

// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes the cpu memory port into on-chip word RAM and an MMIO page (UART TX, GPIO).
// Define MMIO_CYCLE_COUNTER_EN to add the free-running cycle counter at 0xFF03.
module mmio_bridge #(
  parameter int unsigned RAM_AW   = 10,
  parameter int unsigned FIFO_AW  = 2,
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mmio_bridge_if.slave bus,
  output logic         uart_tx,
  output logic [15:0]  gpio_out
);
  localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
  localparam int unsigned PTR_W      = FIFO_AW + 1;
  localparam int unsigned BAUD_W     = $clog2(BAUD_DIV);

  localparam logic [15:0] ADDR_UART_DATA = 16'hFF00;
  localparam logic [15:0] ADDR_UART_STAT = 16'hFF01;
  localparam logic [15:0] ADDR_GPIO      = 16'hFF02;
  localparam logic [15:0] ADDR_CYCLES    = 16'hFF03;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [15:0]       ram_mem  [RAM_DEPTH];
  logic [7:0]        fifo_mem [FIFO_DEPTH];

  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       gpio_q, gpio_d;
  logic              wren_n_q, wren_n_d, oen_n_q, oen_n_d;
  logic [15:0]       cyc_rd;

  logic sel_ram, sel_data, sel_stat, sel_gpio, sel_cyc;
  logic wr_en, push, do_push, pop, stat_rd_first;
  logic fifo_empty, fifo_full, baud_last, tx_busy;
  logic [7:0] fifo_head;

  // Address decode; simultaneous wren_n/oen_n low suppresses every write.
  assign sel_ram       = ~bus.address[15];
  assign sel_data      = bus.address == ADDR_UART_DATA;
  assign sel_stat      = bus.address == ADDR_UART_STAT;
  assign sel_gpio      = bus.address == ADDR_GPIO;
  assign sel_cyc       = bus.address == ADDR_CYCLES;
  assign wr_en         = ~bus.wren_n & bus.oen_n;
  assign push          = wr_en & sel_data & wren_n_q;
  assign stat_rd_first = ~bus.oen_n & oen_n_q & sel_stat;

  assign fifo_empty = wr_ptr_q == rd_ptr_q;
  assign fifo_full  = (wr_ptr_q - rd_ptr_q) == PTR_W'(FIFO_DEPTH);
  assign do_push    = push & ~fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
  assign baud_last  = baud_q == BAUD_W'(BAUD_DIV - 1);
  assign tx_busy    = state_q != S_IDLE;

  // TX frame sequencer; tx_d follows the next state so uart_tx aligns with state_q.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_head;
          bit_idx_d = 3'd0;
          baud_d    = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_head;
            bit_idx_d = 3'd0;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO pointers, sticky overflow, GPIO latch and strobe history.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    overflow_d = overflow_q;
    gpio_d     = gpio_q;
    wren_n_d   = bus.wren_n;
    oen_n_d    = bus.oen_n;
    if (push && fifo_full)  overflow_d = 1'b1;
    else if (stat_rd_first) overflow_d = 1'b0;
    if (wr_en && sel_gpio)  gpio_d = bus.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      gpio_q     <= '0;
      wren_n_q   <= 1'b1;
      oen_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      gpio_q     <= gpio_d;
      wren_n_q   <= wren_n_d;
      oen_n_q    <= oen_n_d;
    end
  end

  // Storage arrays carry no reset; a flushed FIFO is empty by pointer equality.
  always_ff @(posedge clk) begin
    if (wr_en && sel_ram) ram_mem[bus.address[RAM_AW-1:0]] <= bus.wdata;
    if (do_push)          fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= bus.wdata[7:0];
  end

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q + 16'd1;
    if (wr_en && sel_cyc) cyc_d = bus.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = '0;
`endif

  // Zero-latency read mux; the cpu samples it at the closing edge.
  always_comb begin
    bus.rdata = '0;
    if (!bus.oen_n) begin
      if (sel_ram)       bus.rdata = ram_mem[bus.address[RAM_AW-1:0]];
      else if (sel_stat) bus.rdata = {12'd0, overflow_q, tx_busy, fifo_empty, fifo_full};
      else if (sel_gpio) bus.rdata = gpio_q;
      else if (sel_cyc)  bus.rdata = cyc_rd;
    end
  end

  assign uart_tx  = tx_q;
  assign gpio_out = gpio_q;
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: scoreboard bench for mmio_bridge bus decode, UART TX framing, FIFO overflow and reset.
module tb_mmio_bridge;
  localparam int BAUD = 16;

  logic        clk;
  logic        rst_n;
  logic        uart_tx;
  logic [15:0] gpio_out;

  mmio_bridge_if bus ();

  mmio_bridge #(.RAM_AW(10), .FIFO_AW(2), .BAUD_DIV(BAUD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .uart_tx  (uart_tx),
    .gpio_out (gpio_out)
  );

  int n_checks = 0;
  int n_errors = 0;
  int rx_count = 0;
  logic [15:0] rd_q [$];
  logic [7:0]  exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    bus.address = addr;
    bus.wdata   = data;
    bus.wren_n  = 1'b0;
    @(posedge clk); #1;
    bus.wren_n  = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    bus.address = addr;
    bus.oen_n   = 1'b0;
    rd_q.push_back(exp);
    @(negedge clk);
    check_eq(tag, bus.rdata, rd_q.pop_front());
    @(posedge clk); #1;
    bus.oen_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic uart_send(input logic [7:0] b, input bit accepted);
    if (accepted) exp_q.push_back(b);
    bus_write(16'hFF00, {8'h00, b});
  endtask

  // Captures one frame from its first low sample; abandons it if reset arrives.
  task automatic rx_frame(output bit pending);
    logic       s [10*BAUD];
    logic [9:0] lvl;
    logic [15:0] e;
    int         bad;
    pending = 1'b0;
    for (int i = 0; i < 10*BAUD; i++) begin
      if (i > 0) @(negedge clk);
      if (!rst_n) return;
      s[i] = uart_tx;
    end
    bad = 0;
    for (int k = 0; k < 10; k++) lvl[k] = s[k*BAUD + BAUD/2];
    for (int i = 0; i < 10*BAUD; i++) if (s[i] !== lvl[i/BAUD]) bad++;
    e = (exp_q.size() > 0) ? {8'h00, exp_q.pop_front()} : 16'hxxxx;
    rx_count++;
    check_eq("rx_start", 16'(lvl[0]), 16'h0000);
    check_eq("rx_stop", 16'(lvl[9]), 16'h0001);
    check_eq("rx_bit_timing", 16'(bad), 16'h0000);
    check_eq("rx_byte", {8'h00, lvl[8:1]}, e);
    pending = exp_q.size() > 0;
  endtask

  initial begin : uart_mon
    bit pending;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (pending) check_eq("no_gap", 16'(uart_tx), 16'h0000);
      pending = 1'b0;
      if (rst_n && uart_tx === 1'b0) rx_frame(pending);
    end
  end

  initial begin
    rst_n       = 1'b0;
    bus.address = 16'h0000;
    bus.wdata   = 16'h0000;
    bus.wren_n  = 1'b1;
    bus.oen_n   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_uart_tx", 16'(uart_tx), 16'h0001);
    check_eq("rst_gpio", gpio_out, 16'h0000);
    check_eq("rst_rdata_idle", bus.rdata, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_read(16'hFF01, 16'h0002, "rst_stat");

    // RAM, aliasing and the oen_n-high read path
    bus_write(16'h0005, 16'h1234);
    bus_write(16'h03FF, 16'hABCD);
    bus_read(16'h0005, 16'h1234, "ram_rd");
    bus_read(16'h0405, 16'h1234, "ram_alias");
    bus_read(16'h07FF, 16'hABCD, "ram_top_alias");
    bus.address = 16'h0005;
    @(negedge clk);
    check_eq("ram_oen_high", bus.rdata, 16'h0000);
    @(posedge clk); #1;

    // Illegal overlap: read still driven, write dropped
    bus.address = 16'h0005;
    bus.wdata   = 16'hDEAD;
    bus.wren_n  = 1'b0;
    bus.oen_n   = 1'b0;
    @(negedge clk);
    check_eq("illegal_rd", bus.rdata, 16'h1234);
    @(posedge clk); #1;
    bus.wren_n = 1'b1;
    bus.oen_n  = 1'b1;
    @(posedge clk); #1;
    bus_read(16'h0005, 16'h1234, "illegal_no_wr");

    // GPIO and unmapped page
    bus_write(16'hFF02, 16'hA5A5);
    check_eq("gpio_out", gpio_out, 16'hA5A5);
    bus_read(16'hFF02, 16'hA5A5, "gpio_rd");
    bus_write(16'hFF10, 16'h7777);
    bus_read(16'hFF10, 16'h0000, "unmapped_rd");
    bus_read(16'hFF00, 16'h0000, "uart_data_rd");

`ifdef MMIO_CYCLE_COUNTER_EN
    bus.address = 16'hFF03;
    bus.wdata   = 16'hFFFE;
    bus.wren_n  = 1'b0;
    @(posedge clk); #1;
    bus.wren_n  = 1'b1;
    bus.oen_n   = 1'b0;
    @(negedge clk);
    check_eq("cyc_load", bus.rdata, 16'hFFFE);
    @(negedge clk);
    check_eq("cyc_inc", bus.rdata, 16'hFFFF);
    @(negedge clk);
    check_eq("cyc_wrap", bus.rdata, 16'h0000);
    @(posedge clk); #1;
    bus.oen_n = 1'b1;
    @(posedge clk); #1;
`else
    bus_write(16'hFF03, 16'h1234);
    bus_read(16'hFF03, 16'h0000, "cyc_absent");
`endif

    // Single frame
    uart_send(8'h41, 1'b1);
    bus_read(16'hFF01, 16'h0006, "stat_busy");
    idle_cycles(10*BAUD + 10);
    bus_read(16'hFF01, 16'h0002, "stat_done");
    check_eq("rx_count_one", 16'(rx_count), 16'd1);

    // Held strobe queues a single byte
    exp_q.push_back(8'h55);
    bus.address = 16'hFF00;
    bus.wdata   = 16'h0055;
    bus.wren_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.wren_n = 1'b1;
    idle_cycles(10*BAUD + 20);
    check_eq("rx_count_held", 16'(rx_count), 16'd2);

    // Overflow: first byte popped, four queued, sixth dropped
    for (int i = 0; i < 6; i++) uart_send(8'h10 + 8'(i), i < 5);
    bus_read(16'hFF01, 16'h000D, "stat_overflow");
    bus_read(16'hFF01, 16'h0005, "stat_ovf_clr");
    idle_cycles(5*10*BAUD + 40);
    bus_read(16'hFF01, 16'h0002, "stat_drained");
    check_eq("rx_count_ovf", 16'(rx_count), 16'd7);

    // Reset during DATA bit 3 of 0xF0
    uart_send(8'hF0, 1'b1);
    idle_cycles(70);
    check_eq("pre_rst_tx", 16'(uart_tx), 16'h0000);
    rst_n = 1'b0;
    #1;
    check_eq("rst_tx_async", 16'(uart_tx), 16'h0001);
    exp_q.delete();
    idle_cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_read(16'hFF01, 16'h0002, "post_rst_stat");
    check_eq("post_rst_gpio", gpio_out, 16'h0000);
    idle_cycles(10*BAUD + 10);
    check_eq("post_rst_tx", 16'(uart_tx), 16'h0001);
    check_eq("rx_count_final", 16'(rx_count), 16'd7);
    check_eq("exp_q_empty", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
